mac_seq_param: RTL
==================

// Module: mac_seq_param
// PURPOSE
//   Parametrised sequential shift-add multiply-accumulate unit, next generation of the MAC peripheral.
//   Adds signed/unsigned operation and a dual-lane mode (two products per start).
//   Adds a start/busy/done handshake, a saturating accumulator and a saturating output shifter.
//   Sits behind the peripheral register file: operands, control and IRQ go to the bus-side wrapper.
// PARAMETERS
//   DATA_W   16  operand lane width; multiplication takes DATA_W cycles per lane
//   ACC_W    40  accumulator width (>= 2*DATA_W+1)
//   OUT_W    16  width of scaled output mac_out
//   SHIFT_W   3  width of shift select
// PORTS
//   clk          in   1          clock
//   reset        in   1          synchronous, active-high reset
//   start        in   1          request; accepted only in IDLE, ignored while busy
//   clr_acc      in   1          clear accumulator; acted on only in IDLE
//   signed_mode  in   1          1 = two's-complement operands/acc, 0 = unsigned; sampled at accept
//   dual         in   1          1 = lo lanes then hi lanes, both accumulated; sampled at accept
//   op_a         in   2*DATA_W   {hi lane, lo lane} multiplicand; captured at accept
//   op_b         in   2*DATA_W   {hi lane, lo lane} multiplier; captured at accept
//   shift        in   SHIFT_W    output window select
//   irq_en       in   1          interrupt enable
//   irq_ack      in   1          clears irq
//   busy         out  1          operation in progress
//   done         out  1          one-cycle completion pulse
//   acc          out  ACC_W      accumulator
//   mac_out      out  OUT_W      scaled, saturated view of acc (registered)
//   sat          out  1          sticky accumulator-saturation flag
//   irq          out  1          level interrupt
// BEHAVIOUR
//   Reset: state IDLE; busy, done, acc, mac_out, sat and irq all 0; operand regs and bit counter 0.
//     Reset wins mid-operation: no done, acc cleared.
//   FSM: IDLE -> MUL -> ACC -> (dual && lane0 ? MUL with hi lanes : IDLE).
//   Accept: start=1 in IDLE at edge k. MUL runs cycles k+1..k+DATA_W, one multiplier bit per cycle.
//     ACC runs at k+DATA_W+1. done=1 at k+DATA_W+2, with state back in IDLE.
//     Dual mode: second MUL, then ACC; done at k+2*DATA_W+3.
//   busy=1 from k+1 through the last ACC cycle.
//   A new start may be accepted in the cycle done is high.
//   Signed: multiply magnitudes; negate the 2*DATA_W product if the operand signs differ.
//     Sign-extend the product to ACC_W; (-2^(DATA_W-1))^2 is handled exactly.
//     Unsigned: zero-extend the product.
//   ACC: acc <= sat(acc + product).
//     Signed: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Unsigned: clamp to 2^ACC_W-1.
//     Any clamp sets sat.
//   clr_acc in IDLE: acc <= 0 and sat <= 0.
//     clr_acc with start in the same cycle: acc is zeroed, then the new product(s) are added.
//     clr_acc while busy: ignored.
//   mac_out <= window of acc, updated every cycle (one-cycle lag behind acc).
//     Window top bit t = 2*DATA_W-1-shift; window = acc[t -: OUT_W].
//     If acc bits above t are not all equal to the window sign (signed) or not zero (unsigned),
//     clamp to the most-positive / most-negative OUT_W value (unsigned: all ones).
//   irq: set to 1 the cycle after done if irq_en=1; held until irq_ack.
//     irq_ack and a new set in the same cycle: set wins.
// TESTING (DATA_W=16, ACC_W=40, OUT_W=16)
//   1. Unsigned, a=0x8000, b=0x0004, shift=0, start at k -> busy k+1..k+17, done only at k+18,
//      acc=0x20000; next cycle mac_out=0x0002.
//   2. Signed, a=0xFFFD, b=0x0007 -> acc=0xFF_FFFF_FFEB (-21); repeat -> -42.
//      Pulse clr_acc -> acc=0, sat=0.
//   3. Dual, op_a={0x0002,0x0003}, op_b={0x0004,0x0005} -> acc=23, single done at k+35, busy k+1..k+34.
//   4. start held during busy -> exactly one operation.
//      clr_acc+start with acc=100, a=b=2 -> acc=4.
//      clr_acc while busy -> acc unaffected.
//   5. Signed a=b=0x8000, two ops -> acc=0x8000_0000, shift=0 -> mac_out=0x7FFF (clamped).
//      Unsigned acc=0x1_0000_0000 -> mac_out=0xFFFF.
//   6. irq_en=1 -> irq=1 the cycle after done, held until irq_ack.
//      reset during MUL -> busy=0, acc=0, no done, no irq.

Source files
------------

// File: rtl/mac_seq_param.sv
// Sequential shift-add multiply-accumulate unit: signed/unsigned, optional dual-lane,
// saturating accumulator and a registered, saturating output window.
module mac_seq_param #(
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 40,
    parameter int OUT_W   = 16,
    parameter int SHIFT_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clr_acc,
    input  logic                  signed_mode,
    input  logic                  dual,
    input  logic [2*DATA_W-1:0]   op_a,
    input  logic [2*DATA_W-1:0]   op_b,
    input  logic [SHIFT_W-1:0]    shift,
    input  logic                  irq_en,
    input  logic                  irq_ack,
    output logic                  busy,
    output logic                  done,
    output logic [ACC_W-1:0]      acc,
    output logic [OUT_W-1:0]      mac_out,
    output logic                  sat,
    output logic                  irq
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int IDX_W  = $clog2(ACC_W) + 1;

    localparam logic [ACC_W-1:0] ACC_POS_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_NEG_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] OUT_POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_NEG_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ACC  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [PROD_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [PROD_W-1:0] r_prod;
    logic              r_neg;
    logic [DATA_W-1:0] r_hi_a_mag;
    logic [DATA_W-1:0] r_hi_b_mag;
    logic              r_hi_neg;
    logic              r_lane;
    logic              r_dual;
    logic              r_signed;
    logic [CNT_W-1:0]  r_cnt;
    logic [ACC_W-1:0]  r_acc;
    logic              r_sat;
    logic              r_done;
    logic              r_irq;
    logic [OUT_W-1:0]  r_mac_out;

    // Per-lane operand magnitudes and product sign, taken straight from the inputs at accept.
    logic [DATA_W-1:0] w_a_mag [2];
    logic [DATA_W-1:0] w_b_mag [2];
    logic              w_neg   [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [DATA_W-1:0] w_lane_a;
            logic [DATA_W-1:0] w_lane_b;
            logic              w_a_n;
            logic              w_b_n;

            assign w_lane_a    = op_a[gi*DATA_W +: DATA_W];
            assign w_lane_b    = op_b[gi*DATA_W +: DATA_W];
            assign w_a_n       = signed_mode & w_lane_a[DATA_W-1];
            assign w_b_n       = signed_mode & w_lane_b[DATA_W-1];
            assign w_a_mag[gi] = w_a_n ? (~w_lane_a + 1'b1) : w_lane_a;
            assign w_b_mag[gi] = w_b_n ? (~w_lane_b + 1'b1) : w_lane_b;
            assign w_neg[gi]   = w_a_n ^ w_b_n;
        end
    endgenerate

    logic w_last_bit;
    logic w_lane_switch;
    assign w_last_bit    = (r_cnt == CNT_W'(DATA_W - 1));
    assign w_lane_switch = r_dual & ~r_lane;

    // Accumulate in ACC_W+1 bits so both signed and unsigned overflow are visible in the top bits.
    logic [PROD_W-1:0] w_prod_signed;
    logic [ACC_W:0]    w_prod_ext;
    logic [ACC_W:0]    w_acc_ext;
    logic [ACC_W:0]    w_sum;
    logic              w_clamp;
    logic [ACC_W-1:0]  w_acc_next;

    assign w_prod_signed = r_neg ? (~r_prod + 1'b1) : r_prod;
    assign w_prod_ext    = {{(ACC_W+1-PROD_W){r_signed & w_prod_signed[PROD_W-1]}}, w_prod_signed};
    assign w_acc_ext     = {r_signed & r_acc[ACC_W-1], r_acc};
    assign w_sum         = w_acc_ext + w_prod_ext;

    always_comb begin
        w_clamp    = 1'b0;
        w_acc_next = w_sum[ACC_W-1:0];
        if (r_signed) begin
            if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
                w_clamp    = 1'b1;
                w_acc_next = w_sum[ACC_W] ? ACC_NEG_MIN : ACC_POS_MAX;
            end
        end else if (w_sum[ACC_W]) begin
            w_clamp    = 1'b1;
            w_acc_next = {ACC_W{1'b1}};
        end
    end

    // Output window acc[t -: OUT_W] with t = PROD_W-1-shift; bits from t upward must agree.
    logic [IDX_W-1:0] w_top_idx;
    logic [IDX_W-1:0] w_lsb_idx;
    logic [OUT_W-1:0] w_window;
    logic [ACC_W-1:0] w_upper_s;
    logic [ACC_W-1:0] w_upper_u;
    logic             w_fits;
    logic [OUT_W-1:0] w_mac_out_next;

    assign w_top_idx = IDX_W'(PROD_W - 1) - IDX_W'(shift);
    assign w_lsb_idx = w_top_idx - IDX_W'(OUT_W - 1);
    assign w_window  = OUT_W'(r_acc >> w_lsb_idx);
    assign w_upper_s = ACC_W'($signed(r_acc) >>> w_top_idx);
    assign w_upper_u = r_acc >> w_top_idx;

    always_comb begin
        w_mac_out_next = w_window;
        if (r_signed) begin
            w_fits = (w_upper_s == '0) || (&w_upper_s);
            if (!w_fits) begin
                w_mac_out_next = r_acc[ACC_W-1] ? OUT_NEG_MIN : OUT_POS_MAX;
            end
        end else begin
            w_fits = (w_upper_u[ACC_W-1:1] == '0);
            if (!w_fits) begin
                w_mac_out_next = {OUT_W{1'b1}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_MUL;
            S_MUL:   if (w_last_bit) w_state_next = S_ACC;
            S_ACC:   w_state_next = w_lane_switch ? S_MUL : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_prod     <= '0;
            r_neg      <= 1'b0;
            r_hi_a_mag <= '0;
            r_hi_b_mag <= '0;
            r_hi_neg   <= 1'b0;
            r_lane     <= 1'b0;
            r_dual     <= 1'b0;
            r_signed   <= 1'b0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_sat      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clr_acc) begin
                        r_acc <= '0;
                        r_sat <= 1'b0;
                    end
                    if (start) begin
                        r_signed   <= signed_mode;
                        r_dual     <= dual;
                        r_lane     <= 1'b0;
                        r_cnt      <= '0;
                        r_prod     <= '0;
                        r_mcand    <= {{DATA_W{1'b0}}, w_a_mag[0]};
                        r_mplier   <= w_b_mag[0];
                        r_neg      <= w_neg[0];
                        r_hi_a_mag <= w_a_mag[1];
                        r_hi_b_mag <= w_b_mag[1];
                        r_hi_neg   <= w_neg[1];
                    end
                end
                S_MUL: begin
                    if (r_mplier[0]) begin
                        r_prod <= r_prod + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                end
                S_ACC: begin
                    r_acc <= w_acc_next;
                    if (w_clamp) begin
                        r_sat <= 1'b1;
                    end
                    if (w_lane_switch) begin
                        r_lane   <= 1'b1;
                        r_cnt    <= '0;
                        r_prod   <= '0;
                        r_mcand  <= {{DATA_W{1'b0}}, r_hi_a_mag};
                        r_mplier <= r_hi_b_mag;
                        r_neg    <= r_hi_neg;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mac_out <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_mac_out <= w_mac_out_next;
            // A fresh completion takes priority over an acknowledge in the same cycle.
            if (r_done && irq_en) begin
                r_irq <= 1'b1;
            end else if (irq_ack) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign acc     = r_acc;
    assign mac_out = r_mac_out;
    assign sat     = r_sat;
    assign irq     = r_irq;

endmodule
